flop_load_arbiter: RTL and testbench
====================================

Name: flop_load_arbiter

Overview:
- Shares a single enable-gated 8-bit data register (enable / data_in / data_out flop with async active-low reset) among NUM_REQ requesters.
- Uses round-robin arbitration with bounded bursts.
- Holds off all loads for a fixed number of cycles after reset release, so the register is never written while reset is settling.
- Sits directly upstream of the register and drives its enable and data_in.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_W, 8, data width; matches register width
- HOLDOFF_CYC, 4, cycles after reset release during which no grant is issued (>=1)
- MAX_BURST, 4, maximum accepted beats per grant (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  marks final beat of requester's burst
- req_ready  out  NUM_REQ  per-requester accept
- reg_enable  out  1  load strobe to register enable
- reg_data  out  DATA_W  data to register data_in
- grant_id  out  GID_W  index of current/last granted requester; GID_W = max(1,$clog2(NUM_REQ))
- busy  out  1  high in GRANT state
- holdoff_active  out  1  high in HOLDOFF state

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While rst_n=0:
  - state=HOLDOFF, holdoff counter=0, rr pointer=0, beat counter=0.
  - reg_enable=0, reg_data=0, grant_id=0, busy=0, holdoff_active=1, req_ready=0.
- Reset asserted mid-burst: all outputs go to reset values immediately, without waiting for clk. The in-flight beat is dropped.
- HOLDOFF: counter increments each cycle from 0. When counter==HOLDOFF_CYC-1, next state is IDLE. Exactly HOLDOFF_CYC cycles spent here; req_ready=0 throughout.
- IDLE (arbitration cycle):
  - If any req_valid, pick the first set bit scanning from rr pointer upward, wrapping at NUM_REQ.
  - Register the winner into grant_id, clear beat counter, go to GRANT.
  - If none valid, stay in IDLE. grant_id holds its last value.
- GRANT:
  - req_ready[grant_id]=1 (combinational from state and grant_id); all other req_ready=0.
  - Handshake occurs when req_valid[g] & req_ready[g].
  - Release to IDLE on the same edge as any of:
    - handshake with req_last[g]=1;
    - handshake where beat counter reaches MAX_BURST (i.e. the MAX_BURST-th beat);
    - req_valid[g]=0 (no beat accepted that cycle).
  - On release, rr pointer = grant_id+1, wrapping to 0 after NUM_REQ-1.
- Datapath latency 1:
  - On each handshake edge: reg_enable<=1 and reg_data<=that requester's data.
  - Otherwise reg_enable<=0; reg_data holds its value.
  - reg_enable is therefore high exactly one cycle per accepted beat.
- Re-arbitration costs one IDLE bubble cycle between grants. Back-to-back beats within a grant are full rate.
- Requester valid rules: req_valid may rise at any time. Data and last are sampled only on the handshake edge. Valid is not required to stay asserted while waiting.
- Only one requester is granted at a time, so no simultaneous-load conflict can occur. Non-granted requesters see no effect.
- Counter widths:
  - beat counter: $clog2(MAX_BURST+1) bits;
  - holdoff counter: $clog2(HOLDOFF_CYC+1) bits.
  - No wrap is possible, since both counters are bounded by the transition rules.
- grant_id wrap: with NUM_REQ not a power of 2, the pointer wraps explicitly at NUM_REQ, never at 2^GID_W.

Decomposition:
- Package flop_load_arb_pkg holds:
  - state enum {HOLDOFF, IDLE, GRANT} (2-bit);
  - function gid_w(n) returning max(1,$clog2(n)).
- Sub-module rr_pick (combinational): inputs request vector and pointer; outputs winner index and any_valid. Implemented as a double-width rotate / priority scan.
- All state lives in flop_load_arbiter.

Test Plan:
1. Holdoff: rst_n low 3 cycles with req_valid=4'b0001, release.
   - Required: holdoff_active=1 for 4 cycles after release.
   - Required: first req_ready[0]=1 on cycle 6 after release (4 HOLDOFF + 1 IDLE), reg_enable=0 throughout.
2. Single beat: req1 valid, data 0xAA, last=1 after holdoff.
   - Required: one handshake, reg_enable=1 for exactly one cycle with reg_data=0xAA the cycle after handshake.
   - Required: busy drops, grant_id=1.
3. Round robin: all four valid continuously, each last=1, data 0x10/0x11/0x12/0x13.
   - Required: grant order 0,1,2,3,0.
   - Required: reg_data sequence 0x10,0x11,0x12,0x13,0x10, each separated by one idle cycle.
4. Burst cap: req2 valid with last=0 forever, data 0x55,0x56,... and req3 valid.
   - Required: exactly 4 beats 0x55..0x58 accepted from req2, then grant moves to req3.
5. Valid drop: req0 sends 0x01,0x02 with last=0, then deasserts valid one cycle while req1 is pending.
   - Required: req0 released after 2 beats, next grant_id=1.
6. Reset mid-burst: rst_n pulled low between clock edges during a req2 burst.
   - Required: req_ready, reg_enable, reg_data go to 0 immediately (async).
   - Required: after release, full 4-cycle holdoff and pointer=0, so with req0 and req2 both valid the first grant is req0.

Source files
------------

// File: rtl/flop_load_arbiter_pkg.sv
// rtl/flop_load_arbiter_pkg.sv - state encoding and grant index width helper for the flop load arbiter
package flop_load_arb_pkg;

    typedef enum logic [1:0] {
        HOLDOFF = 2'd0,
        IDLE    = 2'd1,
        GRANT   = 2'd2
    } state_e;

    // A two-requester arbiter still needs a one-bit index.
    function automatic int gid_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flop_load_arbiter_if.sv
// rtl/flop_load_arbiter_if.sv - requester-side valid/data/last/ready bundle
interface flop_load_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_data, output req_last, input req_ready);
    modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/flop_load_arbiter_rr_pick.sv
// rtl/flop_load_arbiter_rr_pick.sv - round-robin winner search starting at a pointer, wrapping at N
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_valid
);
    logic [N-1:0] rotated;
    int           sum;

    // Rotate so the pointer lands at bit 0, then the lowest set bit wins.
    always_comb begin
        rotated   = N'({req, req} >> ptr);
        any_valid = |req;
        winner    = '0;
        sum       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                sum = int'(ptr) + i;
                if (sum >= N) begin
                    sum = sum - N;
                end
                winner = W'(sum);
            end
        end
    end
endmodule

// File: rtl/flop_load_arbiter.sv
// rtl/flop_load_arbiter.sv - round-robin, burst-capped arbiter driving a shared enable-gated data register
module flop_load_arbiter
    import flop_load_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLDOFF_CYC = 4,
    parameter int MAX_BURST   = 4,
    localparam int GID_W      = gid_w(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    flop_load_arbiter_if.slave    bus,
    output logic                  reg_enable,
    output logic [DATA_W-1:0]     reg_data,
    output logic [GID_W-1:0]      grant_id,
    output logic                  busy,
    output logic                  holdoff_active
);
    localparam int HC_W = $clog2(HOLDOFF_CYC + 1);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(HOLDOFF_CYC - 1);
    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST);
    localparam logic [GID_W-1:0] LAST_ID    = GID_W'(NUM_REQ - 1);

    state_e             state, state_nxt;
    logic [HC_W-1:0]    hold_cnt, hold_cnt_nxt;
    logic [BC_W-1:0]    beat_cnt, beat_cnt_nxt, beat_cnt_inc;
    logic [GID_W-1:0]   rr_ptr, rr_ptr_nxt, grant_nxt, winner;
    logic               any_valid, handshake, g_valid, g_last, done_burst;
    logic [DATA_W-1:0]  g_data;

    rr_pick #(.N(NUM_REQ), .W(GID_W)) u_pick (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign g_valid        = bus.req_valid[grant_id];
    assign g_last         = bus.req_last[grant_id];
    assign g_data         = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
    assign handshake      = (state == GRANT) && g_valid;
    assign beat_cnt_inc   = beat_cnt + BC_W'(1);
    assign busy           = (state == GRANT);
    assign holdoff_active = (state == HOLDOFF);

    always_comb begin
        bus.req_ready = '0;
        if (state == GRANT) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        beat_cnt_nxt = beat_cnt;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant_id;
        done_burst   = 1'b0;
        case (state)
            HOLDOFF: begin
                hold_cnt_nxt = hold_cnt + HC_W'(1);
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (any_valid) begin
                    grant_nxt    = winner;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                // A cycle with valid low gives up the grant rather than stalling others.
                if (!g_valid) begin
                    done_burst = 1'b1;
                end else begin
                    beat_cnt_nxt = beat_cnt_inc;
                    done_burst   = g_last || (beat_cnt_inc == BURST_LAST);
                end
                if (done_burst) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + GID_W'(1);
                end
            end
            default: state_nxt = HOLDOFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HOLDOFF;
            hold_cnt   <= '0;
            beat_cnt   <= '0;
            rr_ptr     <= '0;
            grant_id   <= '0;
            reg_enable <= 1'b0;
            reg_data   <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            beat_cnt   <= beat_cnt_nxt;
            rr_ptr     <= rr_ptr_nxt;
            grant_id   <= grant_nxt;
            reg_enable <= handshake;
            if (handshake) begin
                reg_data <= g_data;
            end
        end
    end
endmodule

// File: tb/tb_flop_load_arbiter.sv
// tb/tb_flop_load_arbiter.sv - directed bench with a cycle-level reference model and literal expectations
module tb_flop_load_arbiter;
    import flop_load_arb_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int HOLDOFF_CYC = 4;
    localparam int MAX_BURST   = 4;
    localparam int GID_W       = gid_w(NUM_REQ);

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              reg_enable;
    logic [DATA_W-1:0] reg_data;
    logic [GID_W-1:0]  grant_id;
    logic              busy;
    logic              holdoff_active;

    flop_load_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    flop_load_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLDOFF_CYC(HOLDOFF_CYC), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .reg_enable     (reg_enable),
        .reg_data       (reg_data),
        .grant_id       (grant_id),
        .busy           (busy),
        .holdoff_active (holdoff_active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: mode 0 = holding off, 1 = choosing, 2 = serving m_gid.
    int              m_mode  = 0;
    int              m_held  = 0;
    int              m_ptr   = 0;
    int              m_gid   = 0;
    int              m_beats = 0;
    logic            m_en    = 1'b0;
    logic [7:0]      m_data  = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_held <= 0; m_ptr <= 0; m_gid <= 0; m_beats <= 0;
            m_en <= 1'b0; m_data <= 8'h00;
        end else begin : step
            int   mode, held, ptr, gid, beats, c;
            logic took, done;
            mode = m_mode; held = m_held; ptr = m_ptr; gid = m_gid; beats = m_beats;
            took = (m_mode == 2) && bus.req_valid[m_gid];
            done = 1'b0;
            case (m_mode)
                0: begin
                    held = m_held + 1;
                    if (held == HOLDOFF_CYC) mode = 1;
                end
                1: begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        c = (m_ptr + k) % NUM_REQ;
                        if (mode == 1 && bus.req_valid[c]) begin
                            gid = c; beats = 0; mode = 2;
                        end
                    end
                end
                2: begin
                    if (!took) done = 1'b1;
                    else begin
                        beats = m_beats + 1;
                        if (bus.req_last[m_gid] || beats == MAX_BURST) done = 1'b1;
                    end
                    if (done) begin
                        mode = 1;
                        ptr  = (m_gid + 1) % NUM_REQ;
                    end
                end
                default: ;
            endcase
            m_en <= took;
            if (took) m_data <= bus.req_data[m_gid*DATA_W +: DATA_W];
            m_mode <= mode; m_held <= held; m_ptr <= ptr; m_gid <= gid; m_beats <= beats;
        end
    end

    logic [7:0] en_log[$];
    int         en_cyc[$];
    int         gnt_log[$];
    logic       busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        check("ready",    64'(bus.req_ready), (m_mode == 2) ? 64'(1 << m_gid) : 64'd0);
        check("enable",   64'(reg_enable),    64'(m_en));
        check("data",     64'(reg_data),      64'(m_data));
        check("grant_id", 64'(grant_id),      64'(m_gid));
        check("busy",     64'(busy),          64'(m_mode == 2));
        check("holdoff",  64'(holdoff_active), 64'(m_mode == 0));
        if (reg_enable === 1'b1) begin
            en_log.push_back(reg_data);
            en_cyc.push_back(cyc);
        end
        if (busy === 1'b1 && !busy_prev) gnt_log.push_back(int'(grant_id));
        busy_prev = (busy === 1'b1);
    end

    function automatic logic [63:0] en_packed();
        logic [63:0] r = '0;
        foreach (en_log[i]) r = (r << 8) | 64'(en_log[i]);
        return r;
    endfunction

    function automatic logic [63:0] gnt_packed();
        logic [63:0] r = '0;
        foreach (gnt_log[i]) r = (r << 4) | 64'(gnt_log[i]);
        return r;
    endfunction

    task automatic clear_logs();
        en_log.delete(); en_cyc.delete(); gnt_log.delete();
    endtask

    task automatic release_and_count(output int held);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        held = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!holdoff_active) break;
            held++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hcnt, first_rdy, en_seen, held, n0;
        logic found, hs, restore;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;

        // Holdoff after reset
        bus.req_valid = 4'b0001; bus.req_data[7:0] = 8'h77; bus.req_last = 4'b1111;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hcnt = 0; first_rdy = 0; en_seen = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (holdoff_active) hcnt++;
            if (bus.req_ready[0] && first_rdy == 0) first_rdy = c;
            if (reg_enable) en_seen++;
        end
        @(posedge clk); #1 bus.req_valid = '0;
        check("t1_holdoff_cycles", 64'(hcnt), 64'd4);
        check("t1_first_ready", 64'(first_rdy), 64'd6);
        check("t1_no_enable", 64'(en_seen), 64'd0);
        repeat (2) @(negedge clk);

        // Single beat from requester 1
        #1 clear_logs();
        bus.req_valid = 4'b0010; bus.req_data[15:8] = 8'hAA;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.req_ready[1] && bus.req_valid[1]) begin found = 1'b1; break; end
        end
        check("t2_granted", 64'(found), 64'd1);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk);
        check("t2_enable", 64'(reg_enable), 64'd1);
        check("t2_data", 64'(reg_data), 64'hAA);
        @(negedge clk); #1;
        check("t2_enable_off", 64'(reg_enable), 64'd0);
        check("t2_busy", 64'(busy), 64'd0);
        check("t2_grant_id", 64'(grant_id), 64'd1);
        check("t2_beats", 64'(en_log.size()), 64'd1);

        // Round robin from a fresh pointer
        @(posedge clk); #1 rst_n = 1'b0;
        release_and_count(held);
        check("t3_holdoff_len", 64'(held), 64'd4);
        #1 clear_logs();
        bus.req_valid = 4'b1111; bus.req_last = 4'b1111;
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (en_log.size() == 5) break;
        end
        bus.req_valid = '0;
        check("t3_data_seq", en_packed(), 64'h1011121310);
        check("t3_grant_seq", gnt_packed(), 64'h01230);
        if (en_cyc.size() == 5)
            for (int i = 0; i < 4; i++) check("t3_gap", 64'(en_cyc[i+1] - en_cyc[i]), 64'd2);

        // Burst cap on requester 2, then requester 3
        clear_logs();
        bus.req_valid = 4'b1100; bus.req_last = 4'b1000;
        bus.req_data[23:16] = 8'h55; bus.req_data[31:24] = 8'h99;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (en_log.size() == 5) break;
            hs = bus.req_ready[2] && bus.req_valid[2];
            @(posedge clk); #1;
            if (hs) bus.req_data[23:16] = bus.req_data[23:16] + 8'h01;
        end
        bus.req_valid = '0;
        check("t4_data_seq", en_packed(), 64'h5556575899);
        check("t4_grant_seq", gnt_packed(), 64'h23);

        // Valid drop releases requester 0
        clear_logs();
        bus.req_valid = 4'b0011; bus.req_last = 4'b0010;
        bus.req_data[7:0] = 8'h01; bus.req_data[15:8] = 8'h21;
        n0 = 0; restore = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (en_log.size() == 3) break;
            hs = bus.req_ready[0] && bus.req_valid[0];
            @(posedge clk); #1;
            if (restore) begin bus.req_valid[0] = 1'b1; restore = 1'b0; end
            if (hs) begin
                n0++;
                bus.req_data[7:0] = bus.req_data[7:0] + 8'h01;
                if (n0 == 2) begin bus.req_valid[0] = 1'b0; restore = 1'b1; end
            end
        end
        bus.req_valid = '0;
        check("t5_data_seq", en_packed(), 64'h010221);
        check("t5_grant_seq", gnt_packed(), 64'h01);

        // Asynchronous reset in the middle of a requester-2 burst
        clear_logs();
        bus.req_valid = 4'b0101; bus.req_last = 4'b0000;
        bus.req_data[7:0] = 8'h44; bus.req_data[23:16] = 8'h66;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (en_log.size() >= 1) break;
        end
        check("t6_pre_enable", 64'(reg_enable), 64'd1);
        check("t6_pre_grant", 64'(grant_id), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t6_ready", 64'(bus.req_ready), 64'd0);
        check("t6_enable", 64'(reg_enable), 64'd0);
        check("t6_data", 64'(reg_data), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_holdoff", 64'(holdoff_active), 64'd1);
        release_and_count(held);
        check("t6_holdoff_len", 64'(held), 64'd4);
        #1 clear_logs();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (gnt_log.size() >= 1) break;
        end
        check("t6_first_grant", gnt_packed(), 64'h0);
        check("t6_grant_count", 64'(gnt_log.size()), 64'd1);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
